alu_cmd_sequencer: RTL

Command-side initiator for the ALU. It collects an operation frame from the received-byte stream (command, operand A, operand B, function), drives the ALU operand, function and enable lines, and captures the registered ALU result and its valid flag. It then returns the result as two bytes, LSB first, through the transmit-side valid/busy handshake. The block sits between the UART receive path and the ALU, and between the ALU and the UART transmit path.

---
 rtl/alu_cmd_sequencer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/alu_cmd_sequencer.sv
// Command-side ALU initiator: gathers a CC/DD frame from the RX byte stream, runs the ALU,
// and returns the result (LSB first) or an error byte through the TX valid/busy handshake.
module alu_cmd_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int OUT_WIDTH  = 2 * DATA_WIDTH,
  parameter int TIMEOUT    = 15
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  input  logic [OUT_WIDTH-1:0]  ALU_OUT,
  input  logic                  ALU_OUT_VLD,
  input  logic                  TX_BUSY,
  output logic [DATA_WIDTH-1:0] ALU_A,
  output logic [DATA_WIDTH-1:0] ALU_B,
  output logic [3:0]            ALU_FUN,
  output logic                  ALU_EN,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_D_VLD,
  output logic                  SEQ_BUSY,
  output logic                  FRAME_ERR
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [DATA_WIDTH-1:0] CMD_NEW   = DATA_WIDTH'('hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_REUSE = DATA_WIDTH'('hDD);
  localparam logic [DATA_WIDTH-1:0] ERR_BYTE  = DATA_WIDTH'('hEE);
  // Leaving ALU_WAIT on this count means the counter has just reached TIMEOUT.
  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, GET_A, GET_B, GET_FUN, ALU_RUN, ALU_WAIT, TX_LO, TX_HI, TX_ERR
  } state_t;

  state_t                 state, next_state;
  logic [OUT_WIDTH-1:0]   result;
  logic [CNT_W-1:0]       count;
  logic                   frame_err_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      ALU_A       <= '0;
      ALU_B       <= '0;
      ALU_FUN     <= '0;
      result      <= '0;
      count       <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state       <= next_state;
      frame_err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (RX_D_VLD && (RX_P_DATA != CMD_NEW) && (RX_P_DATA != CMD_REUSE))
            frame_err_q <= 1'b1;
        end
        GET_A:   if (RX_D_VLD) ALU_A <= RX_P_DATA;
        GET_B:   if (RX_D_VLD) ALU_B <= RX_P_DATA;
        GET_FUN: if (RX_D_VLD) ALU_FUN <= RX_P_DATA[3:0];
        ALU_RUN: count <= '0;
        ALU_WAIT: begin
          count <= count + CNT_W'(1);
          if (ALU_OUT_VLD)
            result <= ALU_OUT;
          else if (count == CNT_LAST)
            frame_err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    next_state = state;
    ALU_EN     = 1'b0;
    TX_D_VLD   = 1'b0;
    TX_P_DATA  = '0;
    case (state)
      IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == CMD_NEW)
            next_state = GET_A;
          else if (RX_P_DATA == CMD_REUSE)
            next_state = GET_FUN;
        end
      end
      GET_A:   if (RX_D_VLD) next_state = GET_B;
      GET_B:   if (RX_D_VLD) next_state = GET_FUN;
      GET_FUN: if (RX_D_VLD) next_state = ALU_RUN;
      ALU_RUN: begin
        ALU_EN     = 1'b1;
        next_state = ALU_WAIT;
      end
      // A valid result on the final count still wins over the timeout.
      ALU_WAIT: begin
        ALU_EN = 1'b1;
        if (ALU_OUT_VLD)
          next_state = TX_LO;
        else if (count == CNT_LAST)
          next_state = TX_ERR;
      end
      TX_LO: begin
        TX_D_VLD  = 1'b1;
        TX_P_DATA = result[DATA_WIDTH-1:0];
        if (!TX_BUSY) next_state = TX_HI;
      end
      TX_HI: begin
        TX_D_VLD  = 1'b1;
        TX_P_DATA = result[OUT_WIDTH-1:DATA_WIDTH];
        if (!TX_BUSY) next_state = IDLE;
      end
      TX_ERR: begin
        TX_D_VLD  = 1'b1;
        TX_P_DATA = ERR_BYTE;
        if (!TX_BUSY) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign SEQ_BUSY  = (state != IDLE);
  assign FRAME_ERR = frame_err_q;

endmodule
